// File: rtl/frame_pingpong_sched.sv
// Ping-pong frame-buffer scheduler. Two single-port frame banks are shared
// between a pixel writer stream and the 3x3 window generator's read port.
// One bank fills while the other is read. Completed frames are handed to the
// window generator oldest first, one full frame per enable window.
module frame_pingpong_sched #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272,
    parameter int DEPTH  = 130560
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iWrValid,
    input  logic              iWrSof,
    input  logic [DATA_W-1:0] iWrPixel,
    output logic              oWrReady,
    output logic              oWinEn,
    input  logic              iWinCs,
    input  logic [ADDR_W-1:0] iWinAddr,
    input  logic              iWinValid,
    output logic [DATA_W-1:0] oWinPixel,
    output logic              oB0Cs,
    output logic              oB0We,
    output logic [ADDR_W-1:0] oB0Addr,
    output logic [DATA_W-1:0] oB0Wdata,
    input  logic [DATA_W-1:0] iB0Rdata,
    output logic              oB1Cs,
    output logic              oB1We,
    output logic [ADDR_W-1:0] oB1Addr,
    output logic [DATA_W-1:0] oB1Wdata,
    input  logic [DATA_W-1:0] iB1Rdata,
    output logic              oRdBank,
    output logic              oFrameDone,
    output logic              oDrop
);

    // Frame length is clamped to the bank size so a mis-set WIDTH/HEIGHT can
    // never address past the end of a bank.
    localparam int FRAME_PIX = (WIDTH * HEIGHT < DEPTH) ? WIDTH * HEIGHT : DEPTH;
    localparam int VCNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [VCNT_W-1:0] LAST_VCNT = VCNT_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {BANK_FREE, BANK_FILL, BANK_READY, BANK_READ} bankState_t;
    typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_GAP} rdState_t;

    bankState_t        rBankSt [2];
    logic              rOlder;
    rdState_t          rRdState;
    logic [VCNT_W-1:0] rVldCnt;

    logic [ADDR_W-1:0] rWrCnt;
    logic              rWrCs;
    logic              rWrBank;
    logic [ADDR_W-1:0] rWrAddr;
    logic [DATA_W-1:0] rWrData;
    logic              rFillDone;

    logic              fillAny;
    logic              fillBank;
    logic              fillActive;
    logic              free0;
    logic              anyFree;
    logic              freeBank;
    logic              wrXfer;
    logic              wrHit;
    logic              wrTgt;
    logic [ADDR_W-1:0] wrAddr;
    logic              wrLast;
    logic              wrDropNow;
    logic              claim;
    logic              ready0;
    logic              ready1;
    logic              selBank;
    logic              rdStart;
    logic              rdEnd;

    assign fillAny  = (rBankSt[0] == BANK_FILL) || (rBankSt[1] == BANK_FILL);
    assign fillBank = (rBankSt[1] == BANK_FILL);
    // While the last write of a frame is still issuing, its bank stops
    // accepting pixels; a new SOF may already claim the other bank.
    assign fillActive = fillAny & ~rFillDone;
    assign free0    = (rBankSt[0] == BANK_FREE);
    assign anyFree  = free0 || (rBankSt[1] == BANK_FREE);
    assign freeBank = free0 ? 1'b0 : 1'b1;

    assign oWrReady  = fillActive | anyFree;
    assign wrXfer    = iWrValid & oWrReady;
    assign wrHit     = wrXfer & (fillActive | iWrSof);
    assign wrTgt     = fillActive ? fillBank : freeBank;
    assign wrAddr    = (iWrSof || !fillActive) ? '0 : rWrCnt;
    assign wrLast    = (wrAddr == LAST_ADDR);
    assign claim     = wrXfer & ~fillActive & iWrSof;
    // Pixel with no frame open, or an SOF that restarts the open frame.
    assign wrDropNow = wrXfer & (fillActive ? iWrSof : ~iWrSof);

    assign ready0  = (rBankSt[0] == BANK_READY);
    assign ready1  = (rBankSt[1] == BANK_READY);
    assign selBank = (ready0 && ready1) ? rOlder : ready1;
    assign rdStart = (rRdState == RD_IDLE) && (ready0 || ready1);
    assign rdEnd   = (rRdState == RD_RUN) && iWinValid && (rVldCnt == LAST_VCNT);

    // Bank ownership: writer claims/completes, reader takes/releases.
    // NOTE: every register uses <= so all blocks sample the same pre-edge
    // state; blocking assignments here would create order-dependent races.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rBankSt[0] <= BANK_FREE;
            rBankSt[1] <= BANK_FREE;
            rOlder     <= 1'b0;
        end else begin
            if (claim) begin
                rBankSt[freeBank] <= BANK_FILL;
            end
            if (rFillDone) begin
                rBankSt[fillBank] <= BANK_READY;
                if (rBankSt[~fillBank] != BANK_READY) begin
                    rOlder <= fillBank;
                end
            end
            if (rdStart) begin
                rBankSt[selBank] <= BANK_READ;
            end
            if (rdEnd) begin
                rBankSt[oRdBank] <= BANK_FREE;
            end
        end
    end

    // Writer: registered write port, address counter and drop pulse.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rWrCnt    <= '0;
            rWrCs     <= 1'b0;
            rWrBank   <= 1'b0;
            rWrAddr   <= '0;
            rWrData   <= '0;
            rFillDone <= 1'b0;
            oDrop     <= 1'b0;
        end else begin
            rWrCs     <= wrHit;
            rFillDone <= wrHit & wrLast;
            oDrop     <= wrDropNow;
            if (wrHit) begin
                rWrBank <= wrTgt;
                rWrAddr <= wrAddr;
                rWrData <= iWrPixel;
                rWrCnt  <= wrLast ? '0 : wrAddr + ADDR_W'(1);
            end
        end
    end

    // Reader FSM: pick the oldest READY bank, gate the window for one frame.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rRdState   <= RD_IDLE;
            rVldCnt    <= '0;
            oRdBank    <= 1'b0;
            oWinEn     <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            case (rRdState)
                RD_IDLE: begin
                    if (rdStart) begin
                        oRdBank  <= selBank;
                        oWinEn   <= 1'b1;
                        rVldCnt  <= '0;
                        rRdState <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (rdEnd) begin
                        oWinEn     <= 1'b0;
                        oFrameDone <= 1'b1;
                        rRdState   <= RD_GAP;
                    end else if (iWinValid) begin
                        rVldCnt <= rVldCnt + VCNT_W'(1);
                    end
                end
                RD_GAP:  rRdState <= RD_IDLE;
                default: rRdState <= RD_IDLE;
            endcase
        end
    end

    // Bank port steering: filling bank gets the write port, reading bank the
    // window's read port, anything else is held quiet.
    // NOTE: every output gets a default before the branches so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        oB0Cs    = 1'b0;
        oB0We    = 1'b0;
        oB0Addr  = '0;
        oB0Wdata = '0;
        oB1Cs    = 1'b0;
        oB1We    = 1'b0;
        oB1Addr  = '0;
        oB1Wdata = '0;
        if (rWrCs && !rWrBank) begin
            oB0Cs    = 1'b1;
            oB0We    = 1'b1;
            oB0Addr  = rWrAddr;
            oB0Wdata = rWrData;
        end else if (rRdState == RD_RUN && !oRdBank) begin
            oB0Cs   = iWinCs;
            oB0Addr = iWinAddr;
        end
        if (rWrCs && rWrBank) begin
            oB1Cs    = 1'b1;
            oB1We    = 1'b1;
            oB1Addr  = rWrAddr;
            oB1Wdata = rWrData;
        end else if (rRdState == RD_RUN && oRdBank) begin
            oB1Cs   = iWinCs;
            oB1Addr = iWinAddr;
        end
    end

    assign oWinPixel = oRdBank ? iB1Rdata : iB0Rdata;

endmodule

// File: tb/tb_frame_pingpong_sched.sv
// Directed bench for frame_pingpong_sched on a 4x3 frame. Expected writes and
// reads are queued as stimulus is driven and compared as the DUT produces them.
module tb_frame_pingpong_sched;

    localparam int DW  = 24;
    localparam int AW  = 17;
    localparam int DEP = 12;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wrExp_t;

    typedef struct {
        logic          bank;
        logic [DW-1:0] data;
    } rdExp_t;

    logic          iClk;
    logic          iRst;
    logic          iWrValid;
    logic          iWrSof;
    logic [DW-1:0] iWrPixel;
    logic          oWrReady;
    logic          oWinEn;
    logic          iWinCs;
    logic [AW-1:0] iWinAddr;
    logic          iWinValid;
    logic [DW-1:0] oWinPixel;
    logic          oB0Cs, oB0We, oB1Cs, oB1We;
    logic [AW-1:0] oB0Addr, oB1Addr;
    logic [DW-1:0] oB0Wdata, oB1Wdata, iB0Rdata, iB1Rdata;
    logic          oRdBank;
    logic          oFrameDone;
    logic          oDrop;

    frame_pingpong_sched #(
        .DATA_W(DW), .ADDR_W(AW), .WIDTH(4), .HEIGHT(3), .DEPTH(DEP)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iWrValid(iWrValid), .iWrSof(iWrSof), .iWrPixel(iWrPixel), .oWrReady(oWrReady),
        .oWinEn(oWinEn), .iWinCs(iWinCs), .iWinAddr(iWinAddr), .iWinValid(iWinValid),
        .oWinPixel(oWinPixel),
        .oB0Cs(oB0Cs), .oB0We(oB0We), .oB0Addr(oB0Addr), .oB0Wdata(oB0Wdata), .iB0Rdata(iB0Rdata),
        .oB1Cs(oB1Cs), .oB1We(oB1We), .oB1Addr(oB1Addr), .oB1Wdata(oB1Wdata), .iB1Rdata(iB1Rdata),
        .oRdBank(oRdBank), .oFrameDone(oFrameDone), .oDrop(oDrop)
    );

    int     nVec = 0;
    int     nErr = 0;
    int     doneCnt = 0;
    int     dropCnt = 0;
    int     lastStalls = 0;
    int     slowRd = 0;
    int     stubV = 0;
    int     stubIssued = 0;
    int     stubStall = 0;
    bit     stubPend = 0;
    bit     stubEnd = 0;
    wrExp_t wrQ[$];
    rdExp_t rdQ[$];

    logic [DW-1:0] mem0 [0:15];
    logic [DW-1:0] mem1 [0:15];

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Synchronous single-port bank models, one cycle read latency.
    always @(posedge iClk) begin
        if (oB0Cs && oB0We)  mem0[oB0Addr[3:0]] <= oB0Wdata;
        if (oB0Cs && !oB0We) iB0Rdata <= mem0[oB0Addr[3:0]];
        if (oB1Cs && oB1We)  mem1[oB1Addr[3:0]] <= oB1Wdata;
        if (oB1Cs && !oB1We) iB1Rdata <= mem1[oB1Addr[3:0]];
    end

    task automatic wrCheck(input logic b, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wrExp_t e;
        check("wr_expected_pending", wrQ.size() > 0, 1);
        if (wrQ.size() > 0) begin
            e = wrQ.pop_front();
            check("wr_bank", b, e.bank);
            check("wr_addr", addr, e.addr);
            check("wr_data", data, e.data);
        end
    endtask

    // Write-port monitor, pulse counters and bank isolation checks.
    initial begin
        forever begin
            @(negedge iClk);
            #1;
            if (!iRst) begin
                if (oFrameDone) doneCnt++;
                if (oDrop) dropCnt++;
                if (oB0Cs && oB0We) begin
                    wrCheck(1'b0, oB0Addr, oB0Wdata);
                    check("iso_b0", oWinEn && !oRdBank, 0);
                end
                if (oB1Cs && oB1We) begin
                    wrCheck(1'b1, oB1Addr, oB1Wdata);
                    check("iso_b1", oWinEn && oRdBank, 0);
                end
                if (oB0Cs && !oB0We) check("rd_b0_owner", oRdBank, 0);
                if (oB1Cs && !oB1We) check("rd_b1_owner", oRdBank, 1);
            end
        end
    end

    // Window-generator stub: reads DEP addresses after oWinEn rises, returns
    // one iWinValid per read, optionally stalling slowRd cycles per address.
    initial begin
        rdExp_t r;
        iWinCs = 1'b0; iWinAddr = '0; iWinValid = 1'b0;
        forever begin
            @(negedge iClk);
            if (iRst) begin
                stubV = 0; stubIssued = 0; stubStall = 0; stubPend = 0; stubEnd = 0;
                iWinCs = 1'b0; iWinAddr = '0; iWinValid = 1'b0;
            end else begin
                if (stubEnd) begin
                    check("win_en_low_after_last", oWinEn, 0);
                    check("frame_done_pulse", oFrameDone, 1);
                    stubEnd = 0; stubV = 0; stubIssued = 0;
                end
                iWinValid = 1'b0;
                if (stubPend) begin
                    check("rd_expected_pending", rdQ.size() > 0, 1);
                    if (rdQ.size() > 0) begin
                        r = rdQ.pop_front();
                        check("rd_pixel", oWinPixel, r.data);
                        check("rd_bank", oRdBank, r.bank);
                    end
                    iWinValid = 1'b1;
                    stubV++;
                    stubPend = 0;
                    if (stubV == DEP) stubEnd = 1;
                end
                iWinCs = 1'b0;
                if (oWinEn && stubIssued < DEP) begin
                    if (stubStall >= slowRd) begin
                        iWinCs = 1'b1;
                        iWinAddr = AW'(stubIssued);
                        stubIssued++;
                        stubPend = 1;
                        stubStall = 0;
                    end else begin
                        stubStall++;
                    end
                end
            end
        end
    end

    task automatic sendPixel(input bit sof, input logic [DW-1:0] pix, input bit expWr,
                             input bit expBank, input int expAddr, input bit expRd);
        int n = 0;
        @(negedge iClk);
        iWrValid = 1'b1; iWrSof = sof; iWrPixel = pix;
        while (!oWrReady && n < 1000) begin
            @(negedge iClk);
            n++;
        end
        lastStalls = n;
        if (!oWrReady) begin
            check("wr_ready_timeout", oWrReady, 1);
        end else begin
            if (expWr) wrQ.push_back('{bank: expBank, addr: AW'(expAddr), data: pix});
            if (expRd) rdQ.push_back('{bank: expBank, data: pix});
        end
        @(posedge iClk);
    endtask

    task automatic wrIdle();
        @(negedge iClk);
        iWrValid = 1'b0; iWrSof = 1'b0;
    endtask

    task automatic sendFrame(input logic [DW-1:0] base, input bit bank, output int firstStalls);
        for (int i = 0; i < DEP; i++) begin
            sendPixel(i == 0, base + DW'(i), 1, bank, i, 1);
            if (i == 0) firstStalls = lastStalls;
        end
    endtask

    task automatic waitDone(input int target, input int budget, input string tag);
        int n = 0;
        while (doneCnt < target && n < budget) begin
            @(negedge iClk);
            #2;
            n++;
        end
        check(tag, doneCnt, target);
    endtask

    task automatic checkQuiet(input string pfx);
        check({pfx, "_win_en"}, oWinEn, 0);
        check({pfx, "_b0_cs"}, oB0Cs, 0);
        check({pfx, "_b0_we"}, oB0We, 0);
        check({pfx, "_b1_cs"}, oB1Cs, 0);
        check({pfx, "_b1_we"}, oB1We, 0);
        check({pfx, "_frame_done"}, oFrameDone, 0);
        check({pfx, "_drop"}, oDrop, 0);
        check({pfx, "_rd_bank"}, oRdBank, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int base;
        int n;
        iRst = 1'b1; iWrValid = 1'b0; iWrSof = 1'b0; iWrPixel = '0;

        // Reset state.
        #3;
        checkQuiet("reset");
        check("reset_wr_ready", oWrReady, 1);
        repeat (2) @(negedge iClk);
        #3 iRst = 1'b0;

        // Single frame into bank 0, fast reader.
        sendFrame(24'h000001, 1'b0, st);
        check("f1_no_stall", st, 0);
        wrIdle();
        waitDone(1, 300, "f1_done");
        check("f1_rd_drained", rdQ.size(), 0);

        // Pixels without SOF while idle are dropped.
        base = dropCnt;
        for (int i = 0; i < 3; i++) begin
            sendPixel(0, 24'hAA0000 + DW'(i), 0, 0, 0, 0);
            check("nosof_ready", lastStalls, 0);
        end
        wrIdle();
        repeat (3) @(negedge iClk);
        check("nosof_drops", dropCnt - base, 3);

        // A, B, C back to back with a slow reader; C waits for bank 0.
        slowRd = 3;
        sendFrame(24'hA00000, 1'b0, st);
        sendFrame(24'hB00000, 1'b1, st);
        check("b_no_stall", st, 0);
        sendFrame(24'hC00000, 1'b0, st);
        check("c_backpressure", st > 0, 1);
        wrIdle();
        waitDone(4, 2000, "abc_done");

        // SOF reasserted at write index 5 restarts the frame at address 0.
        slowRd = 0;
        base = dropCnt;
        for (int i = 0; i < 5; i++) sendPixel(i == 0, 24'h000500 + DW'(i), 1, 0, i, 0);
        sendPixel(1, 24'h000600, 1, 0, 0, 1);
        for (int i = 1; i < DEP - 1; i++) sendPixel(0, 24'h000600 + DW'(i), 1, 0, i, 1);
        wrIdle();
        repeat (4) @(negedge iClk);
        check("restart_not_ready", oWinEn, 0);
        check("restart_drop", dropCnt - base, 1);
        sendPixel(0, 24'h000600 + DW'(DEP - 1), 1, 0, DEP - 1, 1);
        wrIdle();
        waitDone(5, 300, "restart_done");

        // Reset in the middle of reading bank 1 at valid count 6.
        slowRd = 1;
        sendFrame(24'h700000, 1'b0, st);
        sendFrame(24'h710000, 1'b1, st);
        wrIdle();
        waitDone(6, 1000, "x_done");
        n = 0;
        while (!(stubV == 6 && oRdBank == 1'b1) && n < 1000) begin
            @(negedge iClk);
            #1;
            n++;
        end
        check("midread_reached", stubV, 6);
        #2 iRst = 1'b1;
        #1;
        checkQuiet("midrst");
        check("midrst_wr_q", wrQ.size(), 0);
        rdQ.delete();
        repeat (2) @(negedge iClk);
        #3 iRst = 1'b0;
        sendFrame(24'h800000, 1'b0, st);
        check("post_rst_no_stall", st, 0);
        wrIdle();
        waitDone(7, 1000, "post_rst_done");

        repeat (4) @(negedge iClk);
        check("end_wr_q", wrQ.size(), 0);
        check("end_rd_q", rdQ.size(), 0);
        check("total_drops", dropCnt, 4);
        check("total_done", doneCnt, 7);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/frame_pingpong_sched.md
Name: frame_pingpong_sched

Overview:
- Ping-pong frame-buffer scheduler in front of the 3x3 RGB888 window generator.
- Shares two single-port frame BRAM banks between a pixel writer stream (camera/loader) and the window generator's read port.
- Steers write and read traffic so they never target the same bank.
- Gates the window generator's enable so it processes exactly one complete frame per READY bank, oldest frame first.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- ADDR_W, 17, BRAM address width.
- WIDTH, 480, frame width in pixels.
- HEIGHT, 272, frame height in pixels.
- DEPTH, 130560, pixels per bank; must equal WIDTH*HEIGHT.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iWrValid  in  1  writer pixel valid.
- iWrSof  in  1  marks first pixel of a frame; qualified by iWrValid.
- iWrPixel  in  DATA_W  writer pixel.
- oWrReady  out  1  writer may transfer this cycle.
- oWinEn  out  1  enable to window generator (its iEn).
- iWinCs  in  1  window generator BRAM chip select.
- iWinAddr  in  ADDR_W  window generator BRAM address.
- iWinValid  in  1  window generator output-valid.
- oWinPixel  out  DATA_W  read data returned to window generator.
- oB0Cs, oB0We  out  1 each  bank 0 chip select and write enable.
- oB0Addr  out  ADDR_W  bank 0 address.
- oB0Wdata  out  DATA_W  bank 0 write data.
- iB0Rdata  in  DATA_W  bank 0 read data.
- oB1Cs, oB1We, oB1Addr, oB1Wdata, iB1Rdata  same as bank 0, for bank 1.
- oRdBank  out  1  bank currently being read.
- oFrameDone  out  1  one-cycle pulse when a frame read completes.
- oDrop  out  1  one-cycle pulse on a discarded or restarted write.

Behaviour:
- Per-bank state, 2 bits each: FREE, FILL, READY, READ. At most one bank in FILL and at most one in READ.
- A flag rOlder records which READY bank was filled first.
- Reset (asynchronous, any time, including mid-frame):
  - both banks FREE; write counter 0; valid counter 0; reader FSM RD_IDLE.
  - oWinEn, oB*Cs, oB*We, oFrameDone, oDrop, oRdBank all 0.
  - Partial frames are abandoned.
- Write acceptance:
  - oWrReady = 1 when a bank is in FILL or any bank is FREE; otherwise 0 (backpressure).
  - Transfer = iWrValid & oWrReady.
- Write transfer with no bank in FILL:
  - with iWrSof: claim the lowest-index FREE bank into FILL and write the pixel to address 0.
  - without iWrSof: discard the pixel and pulse oDrop.
- Write transfer while a bank is in FILL:
  - write the pixel at the write counter, then increment.
  - iWrSof mid-fill: restart at address 0, write that pixel there, pulse oDrop; the bank stays in FILL.
- Write port timing: registered, one cycle after the transfer. Cs=We=1, Addr=counter, Wdata=pixel on the filling bank.
- Fill completion: the transfer at address DEPTH-1 moves the bank to READY one cycle later, after its last write has issued. The counter wraps to 0.
- Reader FSM, RD_IDLE:
  - if any bank is READY (if both, choose the rOlder bank), set that bank to READ, set oRdBank, load oWinEn<=1, clear the valid counter.
  - go to RD_RUN.
- Reader FSM, RD_RUN:
  - the READ bank's Cs = iWinCs, We = 0, Addr = iWinAddr (combinational pass-through).
  - oWinPixel = Rdata of bank oRdBank; a mux on the registered select, zero added latency.
  - count iWinValid cycles. On the edge where iWinValid=1 and count = DEPTH-1: oWinEn<=0 (same edge, so the window cannot re-enter fill), bank -> FREE, oFrameDone pulses next cycle.
  - go to RD_GAP.
- Reader FSM, RD_GAP: one cycle with oWinEn=0, then RD_IDLE. Minimum 2 cycles between frames with oWinEn low.
- Simultaneous events:
  - a bank going READ->FREE in the same cycle the writer needs a FREE bank: the bank is claimable the following cycle; oWrReady reflects registered state.
  - fill completion and RD_IDLE selection in the same cycle: the new READY bank is visible the next cycle.
- Non-owning bank ports are Cs=We=0, Addr=0, Wdata=0. The reader never drives the FILL bank and the writer never drives the READ bank.
- Counter widths:
  - write counter ADDR_W bits.
  - valid counter $clog2(DEPTH) bits.
  - no arithmetic overflow beyond the DEPTH-1 wrap.

Test Plan (WIDTH=4, HEIGHT=3, DEPTH=12; window modelled by a bench stub emitting 12 iWinValid pulses after oWinEn rises):
- Reset, then one SOF frame of 12 pixels 0x000001..0x00000C:
  - bank0 writes addr 0..11 with matching data.
  - bank0 READY; oWinEn rises; oRdBank=0; reads return bank0 data.
  - after 12th iWinValid, oWinEn=0 on that edge; oFrameDone pulses once.
- Back-to-back frames A, B, C with slow reader:
  - A->bank0, B->bank1.
  - oWrReady=0 for C until bank0 reaches FREE; C then goes to bank0.
  - read order A, B, C.
- Pixels without SOF while idle: 3 pixels -> no bank writes, oDrop pulses 3 times, oWrReady stays 1.
- SOF reasserted at write index 5: oDrop pulses; that pixel lands at addr 0; bank READY only after 12 further pixels.
- Reset asserted mid-read at valid count 6: all outputs 0 immediately; the next SOF frame fills bank0 from addr 0.
- Isolation under concurrent traffic: assert that the write and read strobes never target the same bank in any cycle.
